// File: rtl/pwm_pkg.sv
// Shared types and constants for the complementary dead-time PWM stage.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DT_TO_HI = 3'd1,
    HI_ON    = 3'd2,
    DT_TO_LO = 3'd3,
    LO_ON    = 3'd4
  } dt_state_t;

  // Smallest gap ever inserted between the two drive sides.
  localparam int DT_MIN = 1;

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One complementary output pair: dead-time FSM, gap counter and registered drives.
module pwm_deadtime_ch
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic                i_pwm_q,
  input  logic [DT_WIDTH-1:0] i_dt_eff,
  output logic                o_hi,
  output logic                o_lo
);

  localparam logic [DT_WIDTH-1:0] CntMin = DT_WIDTH'(DT_MIN);

  dt_state_t           r_state;
  dt_state_t           w_state_nxt;
  logic [DT_WIDTH-1:0] r_cnt;
  logic [DT_WIDTH-1:0] w_cnt_nxt;
  logic                r_prev_side;
  logic                w_prev_side_nxt;
  logic                r_prev_vld;
  logic                w_prev_vld_nxt;
  logic                r_hi;
  logic                r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_prev_side <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_hi        <= 1'b0;
      r_lo        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_prev_side <= w_prev_side_nxt;
      r_prev_vld  <= w_prev_vld_nxt;
      r_hi        <= (w_state_nxt == HI_ON);
      r_lo        <= (w_state_nxt == LO_ON);
    end
  end

  // A reversal mid-gap may snap back to the side that was driven before the gap
  // only when a side was actually driven since the last idle period.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_prev_side_nxt = r_prev_side;
    w_prev_vld_nxt  = r_prev_vld;
    if (!i_run) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_prev_vld_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = i_pwm_q ? DT_TO_HI : DT_TO_LO;
          w_cnt_nxt   = i_dt_eff;
        end
        DT_TO_HI: begin
          if (!i_pwm_q) begin
            if (r_prev_vld && !r_prev_side) begin
              w_state_nxt = LO_ON;
            end else begin
              w_state_nxt = DT_TO_LO;
              w_cnt_nxt   = i_dt_eff;
            end
          end else if (r_cnt <= CntMin) begin
            w_state_nxt     = HI_ON;
            w_prev_side_nxt = 1'b1;
            w_prev_vld_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        HI_ON: begin
          if (!i_pwm_q) begin
            w_state_nxt = DT_TO_LO;
            w_cnt_nxt   = i_dt_eff;
          end
        end
        DT_TO_LO: begin
          if (i_pwm_q) begin
            if (r_prev_vld && r_prev_side) begin
              w_state_nxt = HI_ON;
            end else begin
              w_state_nxt = DT_TO_HI;
              w_cnt_nxt   = i_dt_eff;
            end
          end else if (r_cnt <= CntMin) begin
            w_state_nxt     = LO_ON;
            w_prev_side_nxt = 1'b0;
            w_prev_vld_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        LO_ON: begin
          if (i_pwm_q) begin
            w_state_nxt = DT_TO_HI;
            w_cnt_nxt   = i_dt_eff;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with dead-time insertion and latched fault shutdown.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DT_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic [NUM_CHANNELS-1:0] i_pwm,
  input  logic [DT_WIDTH-1:0]     i_deadtime,
  input  logic                    i_fault,
  input  logic                    i_fault_clr,
  output logic [NUM_CHANNELS-1:0] o_pwm_hi,
  output logic [NUM_CHANNELS-1:0] o_pwm_lo,
  output logic                    o_fault
);

  logic [NUM_CHANNELS-1:0] r_pwm_q;
  logic                    r_fault;
  logic [DT_WIDTH-1:0]     w_dt_eff;
  logic                    w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_q <= '0;
      r_fault <= 1'b0;
    end else begin
      r_pwm_q <= i_pwm;
      if (i_fault) begin
        r_fault <= 1'b1;
      end else if (i_fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign w_dt_eff = (i_deadtime == '0) ? DT_WIDTH'(DT_MIN) : i_deadtime;
  // An incoming fault kills the drives on the same edge that latches it.
  assign w_run    = i_enable & ~r_fault & ~i_fault;
  assign o_fault  = r_fault;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    pwm_deadtime_ch #(
      .DT_WIDTH(DT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_run   (w_run),
      .i_pwm_q (r_pwm_q[g]),
      .i_dt_eff(w_dt_eff),
      .o_hi    (o_pwm_hi[g]),
      .o_lo    (o_pwm_lo[g])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime with a queue-based scoreboard.
module tb_pwm_deadtime;

  localparam int NC = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic [NC-1:0] i_pwm;
  logic [DW-1:0] i_deadtime;
  logic          i_fault;
  logic          i_fault_clr;
  logic [NC-1:0] o_pwm_hi;
  logic [NC-1:0] o_pwm_lo;
  logic          o_fault;

  pwm_deadtime #(.NUM_CHANNELS(NC), .DT_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (i_enable),
    .i_pwm      (i_pwm),
    .i_deadtime (i_deadtime),
    .i_fault    (i_fault),
    .i_fault_clr(i_fault_clr),
    .o_pwm_hi   (o_pwm_hi),
    .o_pwm_lo   (o_pwm_lo),
    .o_fault    (o_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] hi;
    logic [NC-1:0] lo;
    logic          flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Values applied at the next negedge.
  logic          nx_rst = 1'b0, nx_en = 1'b0, nx_f = 1'b0, nx_clr = 1'b0;
  logic [NC-1:0] nx_pwm = '0;
  logic [DW-1:0] nx_dt  = '0;
  logic [NC-1:0] snap_hi, snap_lo;
  logic          snap_f;

  // Reference model: each channel is idle, in a gap heading to a side, or driving a side.
  localparam int M_IDLE = 0, M_GAP = 1, M_ON = 2;
  int m_mode[NC], m_side[NC], m_left[NC], m_has_last[NC], m_last[NC], m_pq[NC];
  int m_flt;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = M_IDLE; m_side[c] = 0; m_left[c] = 0;
      m_has_last[c] = 0; m_last[c] = 0; m_pq[c] = 0;
    end
    m_flt = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int   dte, p;
    bit   run;
    if (!rst_n) begin
      model_reset();
    end else begin
      dte = (i_deadtime == 0) ? 1 : int'(i_deadtime);
      run = i_enable && (m_flt == 0) && !i_fault;
      for (int c = 0; c < NC; c++) begin
        p = m_pq[c];
        if (!run) begin
          m_mode[c] = M_IDLE;
          m_has_last[c] = 0;
        end else if (m_mode[c] == M_IDLE) begin
          m_mode[c] = M_GAP; m_side[c] = p; m_left[c] = dte;
        end else if (m_mode[c] == M_ON) begin
          if (p != m_side[c]) begin
            m_mode[c] = M_GAP; m_side[c] = p; m_left[c] = dte;
          end
        end else begin
          if (p != m_side[c]) begin
            m_side[c] = p;
            if (m_has_last[c] != 0 && m_last[c] == p) m_mode[c] = M_ON;
            else m_left[c] = dte;
          end else if (m_left[c] == 1) begin
            m_mode[c] = M_ON; m_last[c] = m_side[c]; m_has_last[c] = 1;
          end else begin
            m_left[c]--;
          end
        end
      end
      if (i_fault) m_flt = 1;
      else if (i_fault_clr) m_flt = 0;
      for (int c = 0; c < NC; c++) m_pq[c] = int'(i_pwm[c]);
    end
    for (int c = 0; c < NC; c++) begin
      e.hi[c] = (m_mode[c] == M_ON) && (m_side[c] == 1);
      e.lo[c] = (m_mode[c] == M_ON) && (m_side[c] == 0);
    end
    e.flt = (m_flt != 0);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    snap_hi = o_pwm_hi; snap_lo = o_pwm_lo; snap_f = o_fault;
    rst_n = nx_rst; i_enable = nx_en; i_pwm = nx_pwm;
    i_deadtime = nx_dt; i_fault = nx_f; i_fault_clr = nx_clr;
    model_step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Called right after a tick that applied a 1->0 change on channel ch.
  task automatic measure(input int ch, output int fall, output int rise);
    fall = -1; rise = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (fall < 0 && !snap_hi[ch]) fall = k;
      if (rise < 0 && snap_lo[ch]) rise = k;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("outputs", int'({o_pwm_hi, o_pwm_lo, o_fault}), int'(e));
      check("no_overlap", int'(o_pwm_hi & o_pwm_lo), 0);
    end
  end

  initial begin
    int fall, rise, lo_seen, hi_low;
    rst_n = 1'b0; i_enable = 1'b0; i_pwm = '0; i_deadtime = '0;
    i_fault = 1'b0; i_fault_clr = 1'b0;
    model_reset();
    ticks(3);
    check("reset_hi", int'(o_pwm_hi), 0);
    check("reset_lo", int'(o_pwm_lo), 0);
    check("reset_fault", int'(o_fault), 0);

    // Dead time 5, channel 0 high then falling.
    nx_rst = 1; nx_en = 1; nx_dt = 8'd5; nx_pwm = 4'b0001;
    ticks(14);
    check("ch0_hi_on", int'(snap_hi[0]), 1);
    nx_pwm = 4'b0000;
    tick();
    measure(0, fall, rise);
    check("dt5_hi_fall", fall, 2);
    check("dt5_lo_rise", rise, 7);

    // Dead time 0 behaves as a one-cycle gap.
    nx_dt = 8'd0; nx_pwm = 4'b0100;
    ticks(8);
    nx_pwm = 4'b0000;
    tick();
    measure(2, fall, rise);
    check("dt0_hi_fall", fall, 2);
    check("dt0_lo_rise", rise, 3);
    for (int k = 0; k < 6; k++) begin
      nx_pwm = nx_pwm ^ 4'b0100;
      ticks(4);
    end

    // Short low glitch on channel 1 with dead time 8.
    nx_dt = 8'd8; nx_pwm = 4'b0010;
    ticks(20);
    lo_seen = 0; hi_low = 0;
    nx_pwm = 4'b0000;
    tick();
    for (int k = 0; k < 17; k++) begin
      if (k == 2) nx_pwm = 4'b0010;
      tick();
      if (snap_lo[1]) lo_seen++;
      if (!snap_hi[1]) hi_low++;
    end
    check("glitch_lo_never", lo_seen, 0);
    check("glitch_hi_gap", hi_low, 3);

    // Fault latch sequence.
    nx_dt = 8'd3; nx_pwm = 4'b1010;
    ticks(10);
    nx_f = 1;
    tick();
    nx_f = 0;
    tick();
    check("fault_outputs_low", int'({snap_hi, snap_lo}), 0);
    check("fault_set", int'(snap_f), 1);
    nx_f = 1; nx_clr = 1;
    tick();
    nx_f = 0; nx_clr = 0;
    ticks(3);
    check("fault_wins_clr", int'(snap_f), 1);
    nx_clr = 1;
    tick();
    nx_clr = 0;
    ticks(2);
    check("fault_cleared", int'(snap_f), 0);
    ticks(8);

    // Enable drop and re-enable.
    nx_en = 0;
    ticks(4);
    nx_en = 1;
    ticks(10);

    // Asynchronous reset in the middle of a gap.
    nx_dt = 8'd8; nx_pwm = 4'b0101;
    ticks(3);
    @(posedge clk);
    #3;
    nx_rst = 0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_hi", int'(o_pwm_hi), 0);
    check("async_rst_lo", int'(o_pwm_lo), 0);
    check("async_rst_fault", int'(o_fault), 0);
    model_reset();
    ticks(3);
    nx_rst = 1;

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(7) == 0) nx_pwm[c] = ~nx_pwm[c];
      if ($urandom_range(40) == 0) nx_dt = DW'($urandom_range(10));
      if ($urandom_range(150) == 0) nx_en = ~nx_en;
      if (!nx_en && $urandom_range(5) == 0) nx_en = 1;
      nx_f   = ($urandom_range(250) == 0);
      nx_clr = ($urandom_range(25) == 0);
      tick();
    end
    nx_f = 0; nx_clr = 0;
    ticks(2);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the AXI PWM generator.
- Consumes the raw per-channel PWM vector and produces complementary high-side/low-side gate-drive pairs with programmable dead time inserted on every transition.
- Provides a latched fault shutdown that forces all drives low.
- Sits between the PWM core output and the chip pads / gate drivers.

Parameters:
- NUM_CHANNELS, 4, number of PWM channels / complementary output pairs
- DT_WIDTH, 8, width of dead-time count in clk cycles

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_enable  input  1  global drive enable; low forces all channels idle
- i_pwm  input  NUM_CHANNELS  raw PWM from core, synchronous to clk
- i_deadtime  input  DT_WIDTH  dead time in clk cycles, shared by all channels
- i_fault  input  1  synchronous fault request, active high
- i_fault_clr  input  1  single-cycle fault-latch clear
- o_pwm_hi  output  NUM_CHANNELS  high-side drive
- o_pwm_lo  output  NUM_CHANNELS  low-side drive
- o_fault  output  1  fault latch state

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: o_pwm_hi=0, o_pwm_lo=0, o_fault=0, all channel FSMs in IDLE, all counters 0, pwm_q=0.
- Input register: i_pwm is registered into pwm_q every cycle. The FSM acts on pwm_q.
- Outputs: registered and decoded from next-state, so o_pwm_hi and o_pwm_lo are never both 1 in any cycle.
- Effective dead time: dt_eff = (i_deadtime==0) ? 1 : i_deadtime. A gap of at least 1 cycle is always inserted.
- Per-channel FSM states: IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON.
  - IDLE (hi=0, lo=0): if run (i_enable & ~fault_latched), go to DT_TO_HI when pwm_q=1 or DT_TO_LO when pwm_q=0; load cnt=dt_eff.
  - DT_TO_HI (hi=0, lo=0): cnt decrements each cycle; go to HI_ON on the cycle cnt reaches 1. If pwm_q drops to 0 before then, go to LO_ON only if the previous state was LO_ON, else restart as DT_TO_LO with cnt reloaded.
  - HI_ON (hi=1): when pwm_q=0, go to DT_TO_LO and load cnt=dt_eff.
  - DT_TO_LO: mirror of DT_TO_HI.
  - LO_ON (lo=1): when pwm_q=1, go to DT_TO_HI and load cnt=dt_eff.
  - Track the last driven side in a 1-bit prev_side register per channel.
- Latency, i_pwm 1->0 while HI_ON:
  - o_pwm_hi falls 2 clk edges after the i_pwm change.
  - o_pwm_lo rises 2+dt_eff edges after the change.
  - Both-low gap is exactly dt_eff cycles. The 0->1 direction is symmetric.
- Glitch pulses shorter than dt_eff never turn on the opposite side; the channel returns to its previous side with no extra gap.
- i_deadtime is sampled only at counter load. A change mid-gap takes effect at the next transition.
- i_enable low: all channels go to IDLE at the next edge and outputs go low at that edge. Re-enable always passes through a full dead-time gap before driving.
- Fault latch:
  - i_fault=1 sets fault_latched at the next edge. Outputs are forced low at that same edge and all FSMs go to IDLE. o_fault=fault_latched.
  - i_fault_clr clears the latch only when i_fault=0. Simultaneous i_fault and i_fault_clr: fault wins.
- rst_n asserted mid-operation: outputs go low immediately (asynchronous), with no dead-time sequencing.

Decomposition:
- Package pwm_pkg: typedef enum logic [2:0] dt_state_t {IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON}, plus a constant DT_MIN=1.
- Sub-module pwm_deadtime_ch: a single-channel FSM, counter and output registers, instantiated NUM_CHANNELS times via generate.
- The top level holds the input register, the dt_eff computation and the fault latch.

Test Plan:
- i_deadtime=5, enable, ch0 i_pwm held 1 -> ch0 hi rises after 5-cycle gap; on i_pwm 1->0, hi falls 2 edges later, lo rises 7 edges after the change; hi&lo never both 1.
- i_deadtime=0 -> gap measured as exactly 1 cycle on each transition.
- i_deadtime=8, ch1 HI_ON, i_pwm 3-cycle low glitch -> lo never asserts; hi returns with no gap beyond the glitch.
- i_fault pulse while channels driving -> all outputs 0 next edge, o_fault=1; i_fault_clr with i_fault=1 -> o_fault stays 1; clr after fault drops -> o_fault=0, outputs resume after dt_eff gap.
- i_enable low mid-cycle -> outputs 0 next edge; re-enable -> full dt_eff gap before any drive.
- rst_n asserted mid-gap -> outputs 0 asynchronously; after release all channels IDLE, o_fault=0.
